mem_arbiter: RTL
================

# mem_arbiter

Two-port arbiter that shares the single unified instruction/data memory of the multi-cycle RISC-V core between two requesters. Port 0 is the core (the datapath's memory address/write path, sequenced by the core's control FSM). Port 1 is an auxiliary master such as a boot loader or debug port. The block serializes accesses, applies round-robin arbitration on ties, and returns read data with a one-cycle acknowledge pulse. The core's control FSM holds its memory state until `m0_ack`.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MEM_LATENCY`, default 1: cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range 1..15.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset; asserted when 0.
- `m0_req` in 1: core request; held until `m0_ack`.
- `m0_we` in 1: 1 = write, 0 = read.
- `m0_addr` in ADDR_W: core address.
- `m0_wdata` in DATA_W: core write data.
- `m0_rdata` out DATA_W: registered read data; valid when `m0_ack`=1.
- `m0_ack` out 1: one-cycle completion pulse.
- `m1_req`, `m1_we`, `m1_addr`, `m1_wdata`, `m1_rdata`, `m1_ack`: same as the port-0 signals, for port 1.
- `mem_en` out 1: one-cycle access strobe.
- `mem_we` out 1: write enable; held stable while `busy`.
- `mem_addr` out ADDR_W: registered address; held stable while `busy`.
- `mem_wdata` out DATA_W: registered write data; held stable while `busy`.
- `mem_rdata` in DATA_W: memory read data.
- `busy` out 1: a transaction is in flight (ACCESS, WAIT or DONE).
- `owner` out 1: port currently granted; meaningful only while `busy`=1.

## Operation
- FSM states are IDLE, ACCESS, WAIT and DONE.
- IDLE: requests are sampled at the clock edge.
  - If only one port is requesting, it is granted.
  - If both are requesting, the port != `last_owner` is granted.
  - On a grant: `mem_addr`, `mem_we` and `mem_wdata` are latched from the winner, `owner` and `last_owner` are updated, and the FSM goes to ACCESS.
- ACCESS: lasts exactly 1 cycle with `mem_en`=1. The latency counter is loaded with `MEM_LATENCY`, then the FSM goes to WAIT.
- WAIT: the counter decrements each cycle. On the cycle it reads 1:
  - For a read, `mem_rdata` is captured into the owner's `rdata` register.
  - The FSM goes to DONE.
- DONE: the owner's `ack`=1 for exactly 1 cycle, then the FSM goes to IDLE.
  - All `req` inputs are ignored in DONE. The requester drops `req` or presents the next transaction in this cycle, so a held `req` is never double-issued.
- Writes update neither `rdata` register. A port's `rdata` holds its last read value until that port's next read completes.
- A request that loses arbitration stays pending. It is granted in the IDLE state following the winner's DONE, which bounds starvation to one transaction.
- `mem_addr`, `mem_we` and `mem_wdata` do not change from ACCESS through DONE. Requester inputs may change freely after the grant edge.
- Reset values: state=IDLE, `last_owner`=1 (so port 0 wins the first tie), `owner`=0. All of `mem_*` outputs, `m*_rdata`, `m*_ack` and `busy` reset to 0.
- Reset mid-transaction: all outputs go to their reset values asynchronously. No ack is issued for the aborted access, and the requester re-issues it.
- The counter is 4 bits wide; `MEM_LATENCY` outside 1..15 is an elaboration error.

## Timing
- Request sampled at the end of IDLE cycle t:
  - ACCESS in cycle t+1.
  - WAIT in cycles t+2 .. t+1+L.
  - ack in cycle t+2+L.
  - IDLE again in cycle t+3+L.
- Throughput: one transaction per L+3 cycles; 4 cycles when L=1.
- `mem_rdata` is sampled at the end of cycle t+1+L, which is L cycles after the `mem_en` cycle.
- `busy`=1 from cycle t+1 through t+2+L.
- `ack` and `rdata` are registered outputs; no combinational path runs from `req` to any output.

## Structure
- Package `mem_arb_pkg` holds:
  - the state enum typedef (IDLE, ACCESS, WAIT, DONE);
  - owner constants `OWNER_CORE`=0 and `OWNER_AUX`=1;
  - the counter width constant 4.
- No sub-module is needed. Arbitration, the FSM and the latency counter live in one module; with two ports the round-robin pick is a single expression.

## Test plan
- Reset values: hold `reset`=0 with random inputs. All outputs are 0; after release, the state is IDLE and `busy`=0.
- Port-0 read, L=1: read of `m0_addr`=0x100 with memory returning 0xDEADBEEF.
  - `mem_en` pulses once with `mem_addr`=0x100.
  - `m0_ack` arrives 3 cycles after the sample edge with `m0_rdata`=0xDEADBEEF.
- Tie and fairness: both ports request continuously right after reset. Grants go 0,1,0,1 over 4 transactions, with each ack 4 cycles apart.
- Port-1 write: address 0x40, data 0x12345678.
  - `mem_we`=1 and `mem_wdata`=0x12345678 are held stable through DONE.
  - `m1_ack` pulses; `m1_rdata` is unchanged.
- L=3 latency: a read completes with ack exactly 5 cycles after the sample edge. Memory data that is valid only in the capture cycle is still returned correctly.
- Reset in WAIT: assert `reset` during WAIT.
  - `mem_*` outputs and `busy` drop immediately, and no ack is issued.
  - After release, a tie grants port 0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port unified-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } arb_state_t;

  localparam logic OWNER_CORE = 1'b0;
  localparam logic OWNER_AUX  = 1'b1;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising the core (port 0) and an auxiliary master (port 1)
// onto the single unified instruction/data memory; one transaction every MEM_LATENCY+3 cycles.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy,
  output logic              owner
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY);

  arb_state_t       state;
  logic             last_owner;
  logic [CNT_W-1:0] cnt;
  logic             pick;

  // On a tie the port that did not win last time is granted.
  assign pick = m1_req & (~m0_req | (last_owner == OWNER_CORE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWNER_AUX;
      owner      <= OWNER_CORE;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_ack     <= 1'b0;
      m1_ack     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            owner      <= pick;
            last_owner <= pick;
            mem_we     <= pick ? m1_we    : m0_we;
            mem_addr   <= pick ? m1_addr  : m0_addr;
            mem_wdata  <= pick ? m1_wdata : m0_wdata;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en <= 1'b0;
          cnt    <= LAT_LOAD;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == CNT_W'(1)) begin
            if (!mem_we) begin
              if (owner == OWNER_AUX) m1_rdata <= mem_rdata;
              else                    m0_rdata <= mem_rdata;
            end
            if (owner == OWNER_AUX) m1_ack <= 1'b1;
            else                    m0_ack <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // Requests are not sampled here, so a req held through its ack is not reissued.
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
